// File: rtl/knn_vote_reader.sv
// k-NN vote reader: takes one sorted distance/class vector per in_valid
// pulse and tallies the K nearest entries' classes, one rank per cycle.
// It then scans the C class tallies, one per cycle, for the majority
// class, and holds the result on a valid/ready handshake.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid          one-cycle capture pulse (accepted only in IDLE)
//   ascending         1: nearest entry at index 0; 0: at index N-1
//   in, in_type       N packed distances / classes, entry i at slice i
//   in_ready          high while IDLE
//   out_valid         result valid, held until out_ready
//   out_ready         downstream accept
//   out_class         winning class
//   out_votes         vote count of the winning class
//   out_min_dist      distance of the nearest entry
//   overrun           sticky: in_valid seen outside IDLE
module knn_vote_reader #(
    parameter  int L      = 3,
    parameter  int W      = 16,
    parameter  int TYPE_W = 3,
    parameter  int K      = 5,
    localparam int N      = 1 << L,
    localparam int C      = 1 << TYPE_W,
    localparam int VW     = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  ascending,
    input  logic [W*N-1:0]        in,
    input  logic [TYPE_W*N-1:0]   in_type,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TYPE_W-1:0]     out_class,
    output logic [VW-1:0]         out_votes,
    output logic [W-1:0]          out_min_dist,
    output logic                  overrun
);

    if (K < 1 || K > N) begin : g_bad_k
        $error("knn_vote_reader: K must satisfy 1 <= K <= N");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        ARGMAX = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [VW-1:0]     K_LAST = VW'(K - 1);
    localparam logic [TYPE_W-1:0] C_LAST = TYPE_W'(C - 1);

    state_t                         state_q, state_d;
    logic [N-1:0][TYPE_W-1:0]       type_q, type_d;
    logic                           asc_q, asc_d;
    logic [VW-1:0]                  k_q, k_d;
    logic [TYPE_W-1:0]              c_q, c_d;
    logic [C-1:0][VW-1:0]           votes_q, votes_d;
    logic [TYPE_W-1:0]              best_cls_q, best_cls_d;
    logic [VW-1:0]                  best_votes_q, best_votes_d;
    logic [TYPE_W-1:0]              out_class_q, out_class_d;
    logic [VW-1:0]                  out_votes_q, out_votes_d;
    logic [W-1:0]                   min_dist_q, min_dist_d;
    logic                           overrun_q, overrun_d;

    logic [L-1:0]                   k_idx;
    logic [L-1:0]                   idx;
    logic [TYPE_W-1:0]              rank_cls;
    logic                           better;
    logic [TYPE_W-1:0]              scan_cls;
    logic [VW-1:0]                  scan_votes;

    // Only the two end entries of the distance vector can be the nearest.
    logic unused_dist;
    assign unused_dist = ^in;

    // In L bits, N-1-k is simply the bitwise complement of k.
    assign k_idx    = L'(k_q);
    assign idx      = asc_q ? k_idx : ~k_idx;
    assign rank_cls = type_q[idx];

    // Strict compare keeps the lowest class index on ties.
    assign better     = votes_q[c_q] > best_votes_q;
    assign scan_cls   = better ? c_q : best_cls_q;
    assign scan_votes = better ? votes_q[c_q] : best_votes_q;

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        asc_d        = asc_q;
        k_d          = k_q;
        c_d          = c_q;
        votes_d      = votes_q;
        best_cls_d   = best_cls_q;
        best_votes_d = best_votes_q;
        out_class_d  = out_class_q;
        out_votes_d  = out_votes_q;
        min_dist_d   = min_dist_q;
        overrun_d    = overrun_q | (in_valid & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    type_d       = in_type;
                    asc_d        = ascending;
                    min_dist_d   = ascending ? in[W-1:0] : in[W*N-1 -: W];
                    k_d          = '0;
                    c_d          = '0;
                    votes_d      = '0;
                    best_cls_d   = '0;
                    best_votes_d = '0;
                    state_d      = COUNT;
                end
            end
            COUNT: begin
                votes_d[rank_cls] = votes_q[rank_cls] + VW'(1);
                k_d = k_q + VW'(1);
                if (k_q == K_LAST) begin
                    state_d = ARGMAX;
                end
            end
            ARGMAX: begin
                best_cls_d   = scan_cls;
                best_votes_d = scan_votes;
                c_d          = c_q + TYPE_W'(1);
                if (c_q == C_LAST) begin
                    out_class_d = scan_cls;
                    out_votes_d = scan_votes;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            type_q       <= '0;
            asc_q        <= 1'b0;
            k_q          <= '0;
            c_q          <= '0;
            votes_q      <= '0;
            best_cls_q   <= '0;
            best_votes_q <= '0;
            out_class_q  <= '0;
            out_votes_q  <= '0;
            min_dist_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            asc_q        <= asc_d;
            k_q          <= k_d;
            c_q          <= c_d;
            votes_q      <= votes_d;
            best_cls_q   <= best_cls_d;
            best_votes_q <= best_votes_d;
            out_class_q  <= out_class_d;
            out_votes_q  <= out_votes_d;
            min_dist_q   <= min_dist_d;
            overrun_q    <= overrun_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_class    = out_class_q;
    assign out_votes    = out_votes_q;
    assign out_min_dist = min_dist_q;
    assign overrun      = overrun_q;

endmodule
